// File: rtl/cpu_types_pkg.sv
// Shared CPU types: the memory word, RAM handshake states and arbiter FSM states.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      IGNT = 2'd1,
      DGNT = 2'd2
   } arb_state_t;

endpackage

// File: rtl/arb_timer.sv
// Saturating grant-length counter with a sticky flag that sets on the edge
// where the count reaches TIMEOUT. It only raises a flag; it never ends a grant.
module arb_timer #(
   parameter int TIMEOUT = 1023
) (
   input  logic CLK,
   input  logic RST,
   input  logic clr,
   input  logic en,
   output logic flag
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt;

   // count stalled grant cycles, hold at TIMEOUT, latch the flag on arrival
   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt  <= '0;
         flag <= 1'b0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         if (cnt != CW'(TIMEOUT))
            cnt <= cnt + 1'b1;
         if (cnt >= CW'(TIMEOUT - 1))
            flag <= 1'b1;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between icache fetches and dcache loads/stores.
// The dcache wins ties. Build with ARB_FAIR_EN defined to let an icache fetch
// through after MAX_DBURST consecutive dcache grants taken while iREN waited.
module mem_arbiter
   import cpu_types_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int TIMEOUT    = 1023,
   parameter int MAX_DBURST = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              iREN,
   input  logic [ADDR_W-1:0] iaddr,
   output logic              iwait,
   output logic [DATA_W-1:0] iload,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [ADDR_W-1:0] daddr,
   input  logic [DATA_W-1:0] dstore,
   output logic              dwait,
   output logic [DATA_W-1:0] dload,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [ADDR_W-1:0] ramaddr,
   output logic [DATA_W-1:0] ramstore,
   input  logic [DATA_W-1:0] ramload,
   input  logic [1:0]        ramstate,
   output logic              err,
   output logic              timeout
);

   arb_state_t state, state_next;
   ramstate_t  rs;
   logic       fair_i;

   assign rs    = ramstate_t'(ramstate);
   assign iload = ramload;
   assign dload = ramload;

`ifdef ARB_FAIR_EN
   localparam int BW = $clog2(MAX_DBURST + 1);
   logic [BW-1:0] dburst;

   assign fair_i = iREN && (dburst == BW'(MAX_DBURST));

   // count dcache grants won while an icache fetch was left waiting
   always_ff @(posedge CLK) begin
      if (RST)
         dburst <= '0;
      else if (state == IDLE) begin
         if (!iREN || state_next == IGNT)
            dburst <= '0;
         else if (state_next == DGNT && dburst != BW'(MAX_DBURST))
            dburst <= dburst + 1'b1;
      end
   end
`else
   assign fair_i = 1'b0;
`endif

   // state register and sticky error flag
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
         err   <= 1'b0;
      end else begin
         state <= state_next;
         if (state != IDLE && rs == ERROR)
            err <= 1'b1;
      end
   end

   // next state, RAM drive and completion strobes
   always_comb begin
      state_next = state;
      iwait      = 1'b1;
      dwait      = 1'b1;
      ramREN     = 1'b0;
      ramWEN     = 1'b0;
      ramaddr    = '0;
      ramstore   = '0;
      case (state)
         IDLE: begin
            if (fair_i)
               state_next = IGNT;
            else if (dREN || dWEN)
               state_next = DGNT;
            else if (iREN)
               state_next = IGNT;
         end
         IGNT: begin
            ramREN  = iREN;
            ramaddr = iaddr;
            if (!iREN)
               state_next = IDLE;
            else if (rs == ACCESS) begin
               iwait      = 1'b0;
               state_next = IDLE;
            end
         end
         DGNT: begin
            ramREN   = dREN;
            ramWEN   = dWEN;
            ramaddr  = daddr;
            ramstore = dstore;
            if (!(dREN || dWEN))
               state_next = IDLE;
            else if (rs == ACCESS) begin
               dwait      = 1'b0;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .CLK  (CLK),
      .RST  (RST),
      .clr  (state == IDLE && state_next != IDLE),
      .en   (state != IDLE && rs != ACCESS),
      .flag (timeout)
   );

endmodule
